// File: rtl/lcd_ctrl_pkg.sv
// Shared command codes, FSM state encoding and a command classifier for the
// LCD image-window controller.
package lcd_ctrl_pkg;

    localparam logic [3:0] CMD_WRITE    = 4'h0;
    localparam logic [3:0] CMD_UP       = 4'h1;
    localparam logic [3:0] CMD_DOWN     = 4'h2;
    localparam logic [3:0] CMD_LEFT     = 4'h3;
    localparam logic [3:0] CMD_RIGHT    = 4'h4;
    localparam logic [3:0] CMD_MAX      = 4'h5;
    localparam logic [3:0] CMD_MIN      = 4'h6;
    localparam logic [3:0] CMD_AVG      = 4'h7;
    localparam logic [3:0] CMD_ROT_CCW  = 4'h8;
    localparam logic [3:0] CMD_ROT_CW   = 4'h9;
    localparam logic [3:0] CMD_MIRROR_X = 4'hA;
    localparam logic [3:0] CMD_MIRROR_Y = 4'hB;
    localparam logic [3:0] CMD_INVERT   = 4'hC;

    typedef enum logic [2:0] {
        LOAD,
        IDLE,
        EXEC,
        WRITE,
        DONE
    } state_t;

    // True for the codes that rewrite the four window pixels.
    function automatic logic is_win_cmd(input logic [3:0] code);
        return (code >= CMD_MAX) && (code <= CMD_INVERT);
    endfunction

endpackage

// File: rtl/lcd_win_alu.sv
// Combinational 2x2 window operator: max/min/average fill, rotations,
// mirrors and inversion. Any other code passes the window through untouched.
module lcd_win_alu
    import lcd_ctrl_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic [3:0]       cmd,
    input  logic [PIX_W-1:0] a,
    input  logic [PIX_W-1:0] b,
    input  logic [PIX_W-1:0] c,
    input  logic [PIX_W-1:0] d,
    output logic [PIX_W-1:0] a_new,
    output logic [PIX_W-1:0] b_new,
    output logic [PIX_W-1:0] c_new,
    output logic [PIX_W-1:0] d_new
);

    logic [PIX_W-1:0] max_ab, max_cd, max_all;
    logic [PIX_W-1:0] min_ab, min_cd, min_all;
    logic [PIX_W+1:0] sum;
    logic [PIX_W-1:0] avg;

    assign max_ab  = (a > b) ? a : b;
    assign max_cd  = (c > d) ? c : d;
    assign max_all = (max_ab > max_cd) ? max_ab : max_cd;
    assign min_ab  = (a < b) ? a : b;
    assign min_cd  = (c < d) ? c : d;
    assign min_all = (min_ab < min_cd) ? min_ab : min_cd;

    // Two guard bits hold the sum of four pixels; dropping the low two bits
    // is floor(sum/4).
    assign sum = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
    assign avg = sum[PIX_W+1:2];

    // Select the new window contents for the current command.
    always_comb begin
        // NOTE: every output is defaulted before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        a_new = a;
        b_new = b;
        c_new = c;
        d_new = d;
        case (cmd)
            CMD_MAX: begin
                a_new = max_all; b_new = max_all; c_new = max_all; d_new = max_all;
            end
            CMD_MIN: begin
                a_new = min_all; b_new = min_all; c_new = min_all; d_new = min_all;
            end
            CMD_AVG: begin
                a_new = avg; b_new = avg; c_new = avg; d_new = avg;
            end
            CMD_ROT_CCW: begin
                a_new = b; b_new = d; c_new = a; d_new = c;
            end
            CMD_ROT_CW: begin
                a_new = c; b_new = a; c_new = d; d_new = b;
            end
            CMD_MIRROR_X: begin
                a_new = c; b_new = d; c_new = a; d_new = b;
            end
            CMD_MIRROR_Y: begin
                a_new = b; b_new = a; c_new = d; d_new = c;
            end
            CMD_INVERT: begin
                // Bitwise complement equals (2^PIX_W - 1) - p.
                a_new = ~a; b_new = ~b; c_new = ~c; d_new = ~d;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lcd_ctrl_param.sv
// LCD image controller: loads an IMG_W x IMG_W image from ROM, applies
// window commands around an operation point, and writes the image to RAM.
module lcd_ctrl_param
    import lcd_ctrl_pkg::*;
#(
    parameter  int IMG_W = 8,
    parameter  int PIX_W = 8,
    localparam int AW    = 2 * $clog2(IMG_W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       cmd,
    input  logic             cmd_valid,
    output logic             IROM_rd,
    output logic [AW-1:0]    IROM_A,
    input  logic [PIX_W-1:0] IROM_Q,
    output logic             IRAM_valid,
    output logic [AW-1:0]    IRAM_A,
    output logic [PIX_W-1:0] IRAM_D,
    output logic             busy,
    output logic             done
);

    localparam int             LW     = $clog2(IMG_W);
    localparam int             NPIX   = IMG_W * IMG_W;
    localparam logic [AW-1:0]  LAST_A = AW'(NPIX - 1);
    localparam logic [AW-1:0]  A_ONE  = AW'(1);
    localparam logic [LW-1:0]  ONE    = LW'(1);
    localparam logic [LW-1:0]  HALF   = LW'(IMG_W / 2);
    localparam logic [LW-1:0]  PT_MIN = LW'(1);
    localparam logic [LW-1:0]  PT_MAX = LW'(IMG_W - 1);

    state_t           state, state_nxt;
    logic [3:0]       cmd_r;
    logic [LW-1:0]    ox, oy;
    logic [PIX_W-1:0] pix [NPIX];

    logic [AW-1:0]    addr_a, addr_b, addr_c, addr_d;
    logic [PIX_W-1:0] win_a, win_b, win_c, win_d;
    logic [PIX_W-1:0] new_a, new_b, new_c, new_d;

    // Row-major addressing: {row, col} is row*IMG_W + col.
    assign addr_a = {oy - ONE, ox - ONE};
    assign addr_b = {oy - ONE, ox};
    assign addr_c = {oy, ox - ONE};
    assign addr_d = {oy, ox};

    assign win_a = pix[addr_a];
    assign win_b = pix[addr_b];
    assign win_c = pix[addr_c];
    assign win_d = pix[addr_d];

    lcd_win_alu #(.PIX_W(PIX_W)) u_win_alu (
        .cmd   (cmd_r),
        .a     (win_a),
        .b     (win_b),
        .c     (win_c),
        .d     (win_d),
        .a_new (new_a),
        .b_new (new_b),
        .c_new (new_c),
        .d_new (new_d)
    );

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: flops are assigned with <= so every register in the design
        // updates from pre-edge values regardless of statement order.
        if (reset) state <= LOAD;
        else       state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (IROM_rd && (IROM_A == LAST_A)) state_nxt = IDLE;
            IDLE:    if (cmd_valid) state_nxt = (cmd == CMD_WRITE) ? WRITE : EXEC;
            EXEC:    state_nxt = IDLE;
            WRITE:   if (IRAM_A == LAST_A) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = LOAD;
        endcase
    end

    // ROM/RAM sequencing, command latch and operation-point moves.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            IROM_rd    <= 1'b0;
            IROM_A     <= '0;
            IRAM_valid <= 1'b0;
            IRAM_A     <= '0;
            IRAM_D     <= '0;
            ox         <= HALF;
            oy         <= HALF;
            cmd_r      <= '0;
        end else begin
            case (state)
                LOAD: begin
                    // First cycle only raises the read; address 0 is already set.
                    if (!IROM_rd)                IROM_rd <= 1'b1;
                    else if (IROM_A == LAST_A)   IROM_rd <= 1'b0;
                    else                         IROM_A  <= IROM_A + A_ONE;
                end
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_r <= cmd;
                        if (cmd == CMD_WRITE) begin
                            IRAM_valid <= 1'b1;
                            IRAM_A     <= '0;
                            IRAM_D     <= pix[0];
                        end
                    end
                end
                EXEC: begin
                    // Moves that would leave 1..IMG_W-1 are dropped.
                    case (cmd_r)
                        CMD_UP:    if (oy > PT_MIN) oy <= oy - ONE;
                        CMD_DOWN:  if (oy < PT_MAX) oy <= oy + ONE;
                        CMD_LEFT:  if (ox > PT_MIN) ox <= ox - ONE;
                        CMD_RIGHT: if (ox < PT_MAX) ox <= ox + ONE;
                        default: ;
                    endcase
                end
                WRITE: begin
                    if (IRAM_A == LAST_A) begin
                        IRAM_valid <= 1'b0;
                    end else begin
                        IRAM_A <= IRAM_A + A_ONE;
                        IRAM_D <= pix[IRAM_A + A_ONE];
                    end
                end
                default: ;
            endcase
        end
    end

    // Pixel buffer: ROM capture during load, window update during exec.
    always_ff @(posedge clk) begin
        // NOTE: the buffer has no reset; it is always fully reloaded before
        // use, and a reset on a memory array blocks RAM mapping.
        if (state == LOAD && IROM_rd) begin
            pix[IROM_A] <= IROM_Q;
        end else if (state == EXEC && is_win_cmd(cmd_r)) begin
            pix[addr_a] <= new_a;
            pix[addr_b] <= new_b;
            pix[addr_c] <= new_c;
            pix[addr_d] <= new_d;
        end
    end

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Directed bench for lcd_ctrl_param: default 8x8/8-bit instance plus a
// 4x4/4-bit instance, each with a behavioural ROM and RAM.
module tb_lcd_ctrl_param;

    localparam int N  = 64;
    localparam int N4 = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance signals.
    logic       reset, cmd_valid;
    logic [3:0] cmd;
    logic       IROM_rd, IRAM_valid, busy, done;
    logic [5:0] IROM_A, IRAM_A;
    logic [7:0] IROM_Q, IRAM_D;

    // 4x4 instance signals.
    logic       reset4, cmd_valid4;
    logic [3:0] cmd4;
    logic       IROM_rd4, IRAM_valid4, busy4, done4;
    logic [3:0] IROM_A4, IRAM_A4;
    logic [3:0] IROM_Q4, IRAM_D4;

    lcd_ctrl_param dut (
        .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
        .IROM_rd(IROM_rd), .IROM_A(IROM_A), .IROM_Q(IROM_Q),
        .IRAM_valid(IRAM_valid), .IRAM_A(IRAM_A), .IRAM_D(IRAM_D),
        .busy(busy), .done(done)
    );

    lcd_ctrl_param #(.IMG_W(4), .PIX_W(4)) dut4 (
        .clk(clk), .reset(reset4), .cmd(cmd4), .cmd_valid(cmd_valid4),
        .IROM_rd(IROM_rd4), .IROM_A(IROM_A4), .IROM_Q(IROM_Q4),
        .IRAM_valid(IRAM_valid4), .IRAM_A(IRAM_A4), .IRAM_D(IRAM_D4),
        .busy(busy4), .done(done4)
    );

    logic [7:0] rom [N];
    logic [7:0] ram [N];
    int         seen [N];
    logic [7:0] exp_img [N];
    logic [3:0] ram4 [N4];
    int         seen4 [N4];

    int epoch = 0, epoch4 = 0;
    int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, overlap_cnt = 0;
    int rd_cnt4 = 0, wr_cnt4 = 0, done_cnt4 = 0, overlap_cnt4 = 0;
    int n_checks = 0, n_pass = 0;

    // ROM and RAM models act on the falling edge; seen[] stamps which
    // write-out last touched each RAM word.
    always @(negedge clk) begin
        if (IROM_rd) begin
            IROM_Q <= rom[IROM_A];
            rd_cnt <= rd_cnt + 1;
        end
        if (IRAM_valid) begin
            ram[IRAM_A]  <= IRAM_D;
            seen[IRAM_A] <= epoch;
            wr_cnt       <= wr_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
        if (IROM_rd && IRAM_valid) overlap_cnt <= overlap_cnt + 1;
    end

    always @(negedge clk) begin
        if (IROM_rd4) begin
            IROM_Q4 <= 4'd3;
            rd_cnt4 <= rd_cnt4 + 1;
        end
        if (IRAM_valid4) begin
            ram4[IRAM_A4]  <= IRAM_D4;
            seen4[IRAM_A4] <= epoch4;
            wr_cnt4        <= wr_cnt4 + 1;
        end
        if (done4) done_cnt4 <= done_cnt4 + 1;
        if (IROM_rd4 && IRAM_valid4) overlap_cnt4 <= overlap_cnt4 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n = 0;
        while (busy !== 1'b0 && n < limit) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, busy, 0);
    endtask

    // Release reset and follow the full image load.
    task automatic load_after_release(input string tag);
        int rd0;
        rd0   = rd_cnt;
        reset = 1'b0;
        tick();
        check({tag, "_rd_first"}, IROM_rd, 1);
        check({tag, "_a_first"}, IROM_A, 0);
        wait_idle(tag, 200);
        check({tag, "_load_cycles"}, rd_cnt - rd0, N);
    endtask

    // Issue one non-write command; it must hold busy for exactly one cycle.
    task automatic send_cmd(input logic [3:0] c);
        cmd       = c;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check($sformatf("exec_busy_c%0h", c), busy, 1);
        tick();
        check($sformatf("exec_ret_c%0h", c), busy, 0);
    endtask

    // Write the image out and compare every RAM word against exp_img.
    task automatic write_out(input string tag, input bit noisy);
        int d0, w0, n;
        d0 = done_cnt;
        w0 = wr_cnt;
        n  = 0;
        epoch++;
        cmd       = 4'h0;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        while (done_cnt == d0 && n < 300) begin
            if (noisy && n < 20) begin
                cmd       = 4'h5;
                cmd_valid = 1'b1;
            end else begin
                cmd_valid = 1'b0;
            end
            tick();
            n++;
        end
        cmd_valid = 1'b0;
        tick();
        check({tag, "_done_once"}, done_cnt - d0, 1);
        check({tag, "_writes"}, wr_cnt - w0, N);
        check({tag, "_busy_after"}, busy, 0);
        for (int k = 0; k < N; k++)
            check($sformatf("%s_px%0d", tag, k),
                  (seen[k] == epoch) ? {24'd0, ram[k]} : 32'hFFFF, exp_img[k]);
    endtask

    task automatic set_ramp();
        for (int k = 0; k < N; k++) exp_img[k] = 8'(k);
    endtask

    initial begin
        int d0, n, r0, w0;

        reset      = 1'b1;
        cmd        = 4'h0;
        cmd_valid  = 1'b0;
        reset4     = 1'b1;
        cmd4       = 4'h0;
        cmd_valid4 = 1'b0;
        for (int k = 0; k < N; k++) rom[k] = 8'(k);

        tick();
        tick();
        check("rst_busy", busy, 1);
        check("rst_done", done, 0);
        check("rst_rom_rd", IROM_rd, 0);
        check("rst_ram_valid", IRAM_valid, 0);
        check("rst_rom_a", IROM_A, 0);
        check("rst_ram_a", IRAM_A, 0);
        check("rst_ram_d", IRAM_D, 0);

        // Ramp image straight back out.
        load_after_release("load");
        set_ramp();
        write_out("ramp", 1'b0);

        // Max on the centre window (4,4): 27,28,35,36 -> 36.
        send_cmd(4'h5);
        exp_img[27] = 36; exp_img[28] = 36; exp_img[35] = 36; exp_img[36] = 36;
        write_out("max", 1'b0);

        // Fresh ramp, average on the centre window: floor(126/4) = 31.
        reset = 1'b1;
        tick();
        tick();
        load_after_release("load2");
        send_cmd(4'h7);
        set_ramp();
        exp_img[27] = 31; exp_img[28] = 31; exp_img[35] = 31; exp_img[36] = 31;
        write_out("avg", 1'b0);

        // Clamp to (1,1), then rotate CW: 0,1,8,9 -> 8,0,9,1.
        for (int i = 0; i < 5; i++) send_cmd(4'h1);
        for (int i = 0; i < 5; i++) send_cmd(4'h3);
        send_cmd(4'h9);
        // Mirror X: 8,0,9,1 -> 9,1,8,0. Mirror Y: -> 1,9,0,8.
        send_cmd(4'hA);
        send_cmd(4'hB);
        // Down to (1,2), min over 0,8,16,17 -> 0.
        send_cmd(4'h2);
        send_cmd(4'h6);
        // Clamp to (7,7), invert 54,55,62,63 -> 201,200,193,192,
        // rotate CCW -> 200,192,201,193, then a no-op code.
        for (int i = 0; i < 10; i++) send_cmd(4'h4);
        for (int i = 0; i < 10; i++) send_cmd(4'h2);
        send_cmd(4'hC);
        send_cmd(4'h8);
        send_cmd(4'hD);
        exp_img[0]  = 1;   exp_img[1]  = 9;   exp_img[8]  = 0;   exp_img[9]  = 0;
        exp_img[16] = 0;   exp_img[17] = 0;
        exp_img[54] = 200; exp_img[55] = 192; exp_img[62] = 201; exp_img[63] = 193;
        // Commands presented during the write-out must be ignored.
        write_out("moves", 1'b1);

        // Reset in the middle of a write-out.
        cmd       = 4'h0;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (!(IRAM_valid === 1'b1 && IRAM_A == 6'd10) && n < 100) begin
            tick();
            n++;
        end
        check("abort_reach_w10", IRAM_A, 10);
        d0    = done_cnt;
        reset = 1'b1;
        #1;
        check("abort_ram_valid", IRAM_valid, 0);
        check("abort_busy", busy, 1);
        check("abort_ram_a", IRAM_A, 0);
        check("abort_rom_rd", IROM_rd, 0);
        tick();
        tick();
        load_after_release("reload");
        check("abort_no_done", done_cnt - d0, 0);
        set_ramp();
        write_out("reload_out", 1'b0);

        // 4x4, 4-bit: all-3 image, invert at (2,2) -> 5,6,9,10 become 12.
        r0     = rd_cnt4;
        reset4 = 1'b0;
        tick();
        check("w4_rd_first", IROM_rd4, 1);
        check("w4_a_first", IROM_A4, 0);
        n = 0;
        while (busy4 !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        check("w4_load_idle", busy4, 0);
        check("w4_load_cycles", rd_cnt4 - r0, N4);
        cmd4       = 4'hC;
        cmd_valid4 = 1'b1;
        tick();
        cmd_valid4 = 1'b0;
        tick();
        check("w4_exec_ret", busy4, 0);
        epoch4++;
        d0         = done_cnt4;
        w0         = wr_cnt4;
        cmd4       = 4'h0;
        cmd_valid4 = 1'b1;
        tick();
        cmd_valid4 = 1'b0;
        n = 0;
        while (done_cnt4 == d0 && n < 100) begin
            tick();
            n++;
        end
        tick();
        check("w4_done_once", done_cnt4 - d0, 1);
        check("w4_writes", wr_cnt4 - w0, N4);
        for (int k = 0; k < N4; k++)
            check($sformatf("w4_px%0d", k),
                  (seen4[k] == epoch4) ? {28'd0, ram4[k]} : 32'hFFFF,
                  (k == 5 || k == 6 || k == 9 || k == 10) ? 12 : 3);

        check("rd_wr_exclusive", overlap_cnt, 0);
        check("w4_rd_wr_exclusive", overlap_cnt4, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lcd_ctrl_param.md
LCD_CTRL_PARAM -- requirements
Module: lcd_ctrl_param

Interface
REQ-001 SHALL have parameter IMG_W, default 8: image side in pixels, power of 2, range 4..32.
REQ-002 SHALL have parameter PIX_W, default 8: pixel width in bits.
REQ-003 SHALL derive AW = 2*log2(IMG_W) as the address width.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 Ports:
- clk  in  1  clock; all state on posedge.
- reset  in  1  asynchronous, active-high reset.
- cmd  in  4  command code.
- cmd_valid  in  1  cmd qualifier.
- IROM_rd  out  1  ROM read enable.
- IROM_A  out  AW  ROM address.
- IROM_Q  in  PIX_W  ROM data; the ROM updates it at negedge when IROM_rd is high.
- IRAM_valid  out  1  RAM write enable; the RAM writes at negedge.
- IRAM_A  out  AW  RAM address.
- IRAM_D  out  PIX_W  RAM write data.
- busy  out  1  high = commands not accepted.
- done  out  1  one-cycle pulse at end of write-out.

Function
REQ-006 SHALL hold an IMG_W x IMG_W pixel buffer, row-major; address = row*IMG_W + col.
REQ-007 SHALL use FSM states LOAD, IDLE, EXEC, WRITE, DONE; after reset, state SHALL be LOAD.
REQ-008 LOAD behaviour:
- IROM_rd high, IROM_A counts 0..IMG_W^2-1, one address per cycle.
- Data for the address driven at posedge t SHALL be captured at posedge t+1.
- After the last capture, the FSM SHALL go to IDLE.
REQ-009 busy SHALL be high in LOAD, EXEC, WRITE and DONE, and low only in IDLE.
REQ-010 A command SHALL be accepted at posedge only when cmd_valid=1 and the state is IDLE; cmd_valid while busy SHALL be ignored, with no queuing.
REQ-011 The operation point (ox,oy) SHALL reset to (IMG_W/2, IMG_W/2) and always lie within 1..IMG_W-1.
REQ-012 The window SHALL be the 2x2 block a=(oy-1,ox-1), b=(oy-1,ox), c=(oy,ox-1), d=(oy,ox).
REQ-013 Command codes:
- 0 write-out.
- 1 up (oy-1), 2 down (oy+1), 3 left (ox-1), 4 right (ox+1); a move past 1 or IMG_W-1 SHALL leave the point unchanged.
- 5 max, 6 min, 7 average: all four window pixels become that value.
- 8 rotate CCW: a,b,c,d <- b,d,a,c.
- 9 rotate CW: a,b,c,d <- c,a,d,b.
- A mirror X: a,b,c,d <- c,d,a,b.
- B mirror Y: a,b,c,d <- b,a,d,c.
- C invert: each window pixel p <- (2^PIX_W-1) - p.
- D..F no-op.
REQ-014 Average SHALL be floor(sum/4), with sum computed at PIX_W+2 bits; no overflow is allowed.
REQ-015 Commands 1..F SHALL complete in EXEC in exactly one cycle, then return to IDLE; busy SHALL be high for exactly one cycle.
REQ-016 WRITE behaviour:
- IRAM_valid high for IMG_W^2 consecutive cycles.
- IRAM_A counts 0..IMG_W^2-1, with IRAM_D = buffer[IRAM_A], all registered.
REQ-017 After the last write cycle, the FSM SHALL enter DONE for one cycle with done=1, then return to IDLE with buffer and operation point retained.
REQ-018 IROM_rd and IRAM_valid SHALL never be high in the same cycle.

Reset
REQ-019 Reset SHALL asynchronously clear:
- busy=1, done=0, IROM_rd=0, IRAM_valid=0.
- IROM_A, IRAM_A, IRAM_D = 0.
- Address counters = 0; operation point = (IMG_W/2, IMG_W/2).
REQ-020 Reset asserted mid-LOAD, EXEC or WRITE SHALL abort the operation; reload SHALL start from address 0 on the first posedge after release.
REQ-021 Buffer contents need not be reset.

Structure
REQ-022 Package lcd_ctrl_pkg SHALL hold the command-code constants and the FSM state enum.
REQ-023 A combinational sub-module lcd_win_alu (inputs: 4 pixels + cmd; outputs: 4 pixels) SHALL implement codes 5..C.
REQ-024 The top level SHALL own the FSM, counters and buffer.

Verification
REQ-025 Default params, ramp image (pixel=address), cmd 0 -> IRAM[k]=k for all 64 k; done pulses once; 64 valid cycles; load took 64 cycles.
REQ-026 Ramp image, cmds 5, 0 -> IRAM[27],[28],[35],[36]=36; the rest are unchanged.
REQ-027 Ramp image, cmds 1x5 then 3x5, then 9 -> point stays at (1,1) after the clamps; window 0,1,8,9 becomes 8,0,9,1.
REQ-028 Ramp image, cmd 7 on window 27,28,35,36 -> all 31 (sum 126, floor 31.5).
REQ-029 IMG_W=4, PIX_W=4, image all 3, cmd C then 0 -> IRAM[5],[6],[9],[10]=12; 16 writes.
REQ-030 Assert reset at write cycle 10 -> IRAM_valid drops asynchronously; LOAD restarts at IROM_A=0; no done pulse.
